// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - op codes, op type and legality check shared by the n-input gate
package gate_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_NAND = 3'd1;
  localparam op_t OP_OR   = 3'd2;
  localparam op_t OP_NOR  = 3'd3;
  localparam op_t OP_XOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;

  function automatic logic op_is_legal(input op_t op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_reduce_n.sv
// rtl/gate_reduce_n.sv - combinational bitwise reduction of NrOfInputs buses under a selectable op
module gate_reduce_n
  import gate_pkg::*;
#(
  parameter int unsigned NrOfInputs = 5,
  parameter int unsigned BitWidth   = 1
) (
  input  logic [NrOfInputs*BitWidth-1:0] operands,
  input  op_t                            op,
  output logic [BitWidth-1:0]            result
);

  logic [BitWidth-1:0] and_acc;
  logic [BitWidth-1:0] or_acc;
  logic [BitWidth-1:0] xor_acc;

  always_comb begin
    and_acc = '1;
    or_acc  = '0;
    xor_acc = '0;
    for (int i = 0; i < NrOfInputs; i++) begin
      and_acc = and_acc & operands[i*BitWidth +: BitWidth];
      or_acc  = or_acc  | operands[i*BitWidth +: BitWidth];
      xor_acc = xor_acc ^ operands[i*BitWidth +: BitWidth];
    end
  end

  // Illegal codes never reach here (the op register rejects them); zero is a safe fallback.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = and_acc;
      OP_NAND: result = ~and_acc;
      OP_OR:   result = or_acc;
      OP_NOR:  result = ~or_acc;
      OP_XOR:  result = xor_acc;
      OP_XNOR: result = ~xor_acc;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_gate_n_inputs.sv
// rtl/pipelined_gate_n_inputs.sv - two-stage valid/ready pipelined n-input gate with runtime op select
module pipelined_gate_n_inputs
  import gate_pkg::*;
#(
  parameter int unsigned           NrOfInputs  = 5,
  parameter int unsigned           BitWidth    = 1,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0,
  parameter op_t                   DefaultOp   = OP_NAND
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [2:0]                     Op_Sel,
  input  logic                           Op_Load,
  output logic                           Op_Err,
  input  logic                           In_Valid,
  output logic                           In_Ready,
  input  logic [NrOfInputs*BitWidth-1:0] Inputs,
  output logic                           Out_Valid,
  input  logic                           Out_Ready,
  output logic [BitWidth-1:0]            Result,
  output logic [15:0]                    Xfer_Count
);

  localparam int unsigned FlatW = NrOfInputs * BitWidth;

  op_t                 op_q,          op_d;
  logic                op_err_q,      op_err_d;
  logic                s1_valid_q,    s1_valid_d;
  logic [FlatW-1:0]    s1_data_q,     s1_data_d;
  op_t                 s1_op_q,       s1_op_d;
  logic                s2_valid_q,    s2_valid_d;
  logic [BitWidth-1:0] s2_result_q,   s2_result_d;
  logic [15:0]         xfer_count_q,  xfer_count_d;

  logic                s2_ready;
  logic                s1_ready;
  logic                accept;
  logic                s1_advance;
  logic                out_fire;
  logic [FlatW-1:0]    bubble_flat;
  logic [BitWidth-1:0] reduce_result;

  for (genvar g = 0; g < NrOfInputs; g++) begin : g_bubble
    assign bubble_flat[g*BitWidth +: BitWidth] = {BitWidth{BubblesMask[g]}};
  end

  // Ready ripples backwards from the consumer; nothing here looks at In_Valid.
  always_comb begin
    s2_ready   = !s2_valid_q || Out_Ready;
    s1_ready   = !s1_valid_q || s2_ready;
    accept     = In_Valid && s1_ready;
    s1_advance = s1_valid_q && s2_ready;
    out_fire   = s2_valid_q && Out_Ready;
  end

  gate_reduce_n #(
    .NrOfInputs (NrOfInputs),
    .BitWidth   (BitWidth)
  ) u_reduce (
    .operands (s1_data_q),
    .op       (s1_op_q),
    .result   (reduce_result)
  );

  always_comb begin
    op_d     = op_q;
    op_err_d = 1'b0;
    if (Op_Load) begin
      if (op_is_legal(Op_Sel)) begin
        op_d = Op_Sel;
      end else begin
        op_err_d = 1'b1;
      end
    end
  end

  // Stage 1 samples op_q, not op_d, so a same-cycle Op_Load only affects later accepts.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = Inputs ^ bubble_flat;
      s1_op_d    = op_q;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_advance) begin
      s2_result_d = reduce_result;
    end
  end

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_fire) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q         <= DefaultOp;
      op_err_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_op_q      <= DefaultOp;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      xfer_count_q <= 16'd0;
    end else begin
      op_q         <= op_d;
      op_err_q     <= op_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_op_q      <= s1_op_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign Op_Err     = op_err_q;
  assign In_Ready   = s1_ready;
  assign Out_Valid  = s2_valid_q;
  assign Result     = s2_result_q;
  assign Xfer_Count = xfer_count_q;

endmodule

// File: tb/tb_pipelined_gate_n_inputs.sv
// tb/tb_pipelined_gate_n_inputs.sv - bench for pipelined_gate_n_inputs (5x1 default and 3x8 bubbled)
module tb_pipelined_gate_n_inputs;
  import gate_pkg::*;

  localparam int AN = 5;
  localparam int AW = 1;
  localparam int BN = 3;
  localparam int BW = 8;
  localparam logic [AN-1:0] AMASK = 5'b00000;
  localparam logic [BN-1:0] BMASK = 3'b010;

  logic clk;
  logic rst;

  logic [2:0]       a_op_sel;
  logic             a_op_load, a_op_err, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [AN*AW-1:0] a_inputs;
  logic [AW-1:0]    a_result;
  logic [15:0]      a_xfer_count;

  logic [2:0]       b_op_sel;
  logic             b_op_load, b_op_err, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BN*BW-1:0] b_inputs;
  logic [BW-1:0]    b_result;
  logic [15:0]      b_xfer_count;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_gate_n_inputs dut_a (
    .Clock(clk), .Reset(rst), .Op_Sel(a_op_sel), .Op_Load(a_op_load), .Op_Err(a_op_err),
    .In_Valid(a_in_valid), .In_Ready(a_in_ready), .Inputs(a_inputs),
    .Out_Valid(a_out_valid), .Out_Ready(a_out_ready), .Result(a_result), .Xfer_Count(a_xfer_count)
  );

  pipelined_gate_n_inputs #(.NrOfInputs(BN), .BitWidth(BW), .BubblesMask(BMASK), .DefaultOp(OP_NAND)) dut_b (
    .Clock(clk), .Reset(rst), .Op_Sel(b_op_sel), .Op_Load(b_op_load), .Op_Err(b_op_err),
    .In_Valid(b_in_valid), .In_Ready(b_in_ready), .Inputs(b_inputs),
    .Out_Valid(b_out_valid), .Out_Ready(b_out_ready), .Result(b_result), .Xfer_Count(b_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per bit position: count asserted (post-bubble) inputs and decide from the count.
  function automatic logic [63:0] ref_reduce(input logic [2:0] op, input logic [255:0] flat,
                                             input int n, input int w, input logic [31:0] mask);
    logic [63:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < w; b++) begin
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(flat[i*w + b] ^ mask[i]);
      case (op)
        3'd0: r[b] = (ones == n);
        3'd1: r[b] = (ones != n);
        3'd2: r[b] = (ones > 0);
        3'd3: r[b] = (ones == 0);
        3'd4: r[b] = (ones % 2 == 1);
        3'd5: r[b] = (ones % 2 == 0);
        default: r[b] = 1'b0;
      endcase
    end
    return r;
  endfunction

  logic [63:0] a_exp_q[$];
  logic [63:0] a_obs_q[$];
  logic [2:0]  a_op_m;
  logic [15:0] a_cnt_m;
  logic        a_err_m;

  logic [63:0] b_exp_q[$];
  logic [2:0]  b_op_m;
  logic [15:0] b_cnt_m;
  logic        b_err_m;

  always @(negedge clk) begin
    if (rst) begin
      a_exp_q.delete();
      a_op_m  = 3'd1;
      a_cnt_m = 16'd0;
      a_err_m = 1'b0;
    end else begin
      check_eq("a_op_err", 64'(a_op_err), 64'(a_err_m));
      check_eq("a_xfer_count", 64'(a_xfer_count), 64'(a_cnt_m));
      if (a_out_valid && a_out_ready) begin
        check_eq("a_output_expected", 64'(a_exp_q.size() != 0), 64'd1);
        if (a_exp_q.size() != 0) check_eq("a_result", 64'(a_result), a_exp_q.pop_front());
        a_obs_q.push_back(64'(a_result));
        a_cnt_m = a_cnt_m + 16'd1;
      end
      if (a_in_valid && a_in_ready)
        a_exp_q.push_back(ref_reduce(a_op_m, 256'(a_inputs), AN, AW, 32'(AMASK)));
      a_err_m = a_op_load && (a_op_sel > 3'd5);
      if (a_op_load && a_op_sel <= 3'd5) a_op_m = a_op_sel;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_exp_q.delete();
      b_op_m  = 3'd1;
      b_cnt_m = 16'd0;
      b_err_m = 1'b0;
    end else begin
      check_eq("b_op_err", 64'(b_op_err), 64'(b_err_m));
      check_eq("b_xfer_count", 64'(b_xfer_count), 64'(b_cnt_m));
      if (b_out_valid && b_out_ready) begin
        check_eq("b_output_expected", 64'(b_exp_q.size() != 0), 64'd1);
        if (b_exp_q.size() != 0) check_eq("b_result", 64'(b_result), b_exp_q.pop_front());
        b_cnt_m = b_cnt_m + 16'd1;
      end
      if (b_in_valid && b_in_ready)
        b_exp_q.push_back(ref_reduce(b_op_m, 256'(b_inputs), BN, BW, 32'(BMASK)));
      b_err_m = b_op_load && (b_op_sel > 3'd5);
      if (b_op_load && b_op_sel <= 3'd5) b_op_m = b_op_sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_op_load = 1'b0; a_out_ready = 1'b1; a_op_sel = 3'd0; a_inputs = '0;
    b_in_valid = 1'b0; b_op_load = 1'b0; b_out_ready = 1'b1; b_op_sel = 3'd0; b_inputs = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_inputs    = 5'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_op_load   = ($urandom_range(0, 7) == 0);
      a_op_sel    = 3'($urandom_range(0, 7));
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_inputs    = 24'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_op_load   = ($urandom_range(0, 7) == 0);
      b_op_sel    = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (5) tick();
  endtask

  logic [4:0] v3 [4];
  logic       e3 [4];
  int         idx;
  int         gaps;

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(a_in_ready), 64'd1);
    check_eq("rst_result", 64'(a_result), 64'd0);
    check_eq("rst_xfer", 64'(a_xfer_count), 64'd0);
    tick();

    // 1: default NAND, two-cycle latency
    a_in_valid = 1'b1; a_inputs = 5'b11111;
    @(negedge clk);
    check_eq("t1_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    a_inputs = 5'b10111;
    @(negedge clk);
    check_eq("t1_valid_c1", 64'(a_out_valid), 64'd0);
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_valid_c2", 64'(a_out_valid), 64'd1);
    check_eq("t1_res_11111", 64'(a_result), 64'd0);
    tick();
    @(negedge clk);
    check_eq("t1_valid_c3", 64'(a_out_valid), 64'd1);
    check_eq("t1_res_10111", 64'(a_result), 64'd1);
    tick();
    @(negedge clk);
    check_eq("t1_valid_c4", 64'(a_out_valid), 64'd0);
    tick();

    // 2: 3x8, bubble on bus 1, XOR
    b_op_load = 1'b1; b_op_sel = OP_XOR;
    tick();
    b_op_load = 1'b0; b_in_valid = 1'b1; b_inputs = {8'hAA, 8'h0F, 8'hF0};
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_valid_c1", 64'(b_out_valid), 64'd0);
    tick();
    @(negedge clk);
    check_eq("t2_valid_c2", 64'(b_out_valid), 64'd1);
    check_eq("t2_result", 64'(b_result), 64'hAA);
    tick();

    // 3: backpressure
    do_reset();
    a_obs_q.delete();
    v3[0] = 5'b11111; v3[1] = 5'b00000; v3[2] = 5'b11111; v3[3] = 5'b01010;
    e3[0] = 1'b0;     e3[1] = 1'b1;     e3[2] = 1'b0;     e3[3] = 1'b1;
    a_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) a_out_ready = 1'b1;
      a_in_valid = (idx < 4);
      a_inputs   = v3[(idx < 4) ? idx : 0];
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        check_eq("t3_stall_valid", 64'(a_out_valid), 64'd1);
        check_eq("t3_stall_result", 64'(a_result), 64'(e3[0]));
      end
      if (c == 4) begin
        check_eq("t3_accepts_while_stalled", 64'(idx), 64'd2);
        check_eq("t3_in_ready_low", 64'(a_in_ready), 64'd0);
      end
      if (a_in_valid && a_in_ready) idx++;
      tick();
    end
    check_eq("t3_out_count", 64'(a_obs_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < a_obs_q.size()) check_eq("t3_order", a_obs_q[i], 64'(e3[i]));
    check_eq("t3_xfer", 64'(a_xfer_count), 64'd4);

    // 4: op change while data is in flight
    do_reset();
    a_obs_q.delete();
    a_in_valid = 1'b1; a_inputs = 5'b01111;
    tick();
    a_op_load = 1'b1; a_op_sel = OP_OR; a_inputs = 5'b11111;
    tick();
    a_op_load = 1'b0; a_inputs = 5'b00000;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    check_eq("t4_out_count", 64'(a_obs_q.size()), 64'd3);
    if (a_obs_q.size() == 3) begin
      check_eq("t4_a_nand", a_obs_q[0], 64'd1);
      check_eq("t4_b_nand", a_obs_q[1], 64'd0);
      check_eq("t4_c_or", a_obs_q[2], 64'd0);
    end

    // 5: illegal op load, then reset with two items in flight
    a_op_load = 1'b1; a_op_sel = 3'd7;
    tick();
    a_op_load = 1'b0;
    @(negedge clk);
    check_eq("t5_op_err_pulse", 64'(a_op_err), 64'd1);
    tick();
    @(negedge clk);
    check_eq("t5_op_err_clear", 64'(a_op_err), 64'd0);
    tick();
    a_obs_q.delete();
    a_in_valid = 1'b1; a_inputs = 5'b11111;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    check_eq("t5_op_kept_count", 64'(a_obs_q.size()), 64'd1);
    if (a_obs_q.size() == 1) check_eq("t5_op_kept_or", a_obs_q[0], 64'd1);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_inputs = 5'($urandom);
    tick();
    a_inputs = 5'($urandom);
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_full_valid", 64'(a_out_valid), 64'd1);
    check_eq("t5_pre_rst_xfer", 64'(a_xfer_count), 64'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_valid", 64'(a_out_valid), 64'd0);
    check_eq("t5_rst_xfer", 64'(a_xfer_count), 64'd0);
    check_eq("t5_rst_in_ready", 64'(a_in_ready), 64'd1);
    repeat (3) tick();
    check_eq("t5_nothing_after_rst", 64'(a_xfer_count), 64'd0);

    // Randomized traffic on both instances
    random_phase(2000);

    // 6: counter wrap under a continuous stream
    do_reset();
    gaps = 0;
    for (int c = 0; c < 65540; c++) begin
      a_in_valid = (c < 65536);
      a_inputs   = 5'($urandom);
      @(negedge clk);
      if (c >= 2 && c < 65538 && !a_out_valid) gaps++;
      if (c == 40000) check_eq("t6_mid_count", 64'(a_xfer_count), 64'd39998);
      tick();
    end
    check_eq("t6_no_valid_gap", 64'(gaps), 64'd0);
    check_eq("t6_wrap_count", 64'(a_xfer_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
